// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for seven-segment display logic.
//   SEG_A..SEG_G : bit positions of segments a..g in a seg bus
//   SEG_P        : bit position of the decimal point
//   FONT         : hex digit glyphs, active-high {g,f,e,d,c,b,a}, index = nibble
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_P = 7;

    // Entry 15 is listed first (packed array, MSB-first).
    localparam logic [15:0][6:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/hex7seg_dec.sv
// ---------------------------------------------------------------------------
// hex7seg_dec
// Combinational hex-to-seven-segment glyph lookup.
//   i_nib : 4-bit hex value
//   o_seg : active-high segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = FONT[i_nib];

endmodule

// File: rtl/hex_scan_display.sv
// ---------------------------------------------------------------------------
// hex_scan_display
// Time-multiplexed driver for a DIGITS-wide hex seven-segment display.
// Each digit owns a slot of 2^DIV_BITS clocks; the first GUARD clocks of a
// slot keep every anode off to avoid ghosting while the segments switch.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   data   : 4*DIGITS bits, nibble i is digit i (digit 0 rightmost)
//   point  : decimal point per digit
//   blank  : force digit fully dark (overrides point and suppression)
//   LE     : 0 = inputs captured every cycle, 1 = hold captured values
//   lz_en  : leading-zero suppression enable
//   seg    : registered segments {p,g,f,e,d,c,b,a}
//   an     : registered digit enables, bit i = digit i
// ---------------------------------------------------------------------------
module hex_scan_display
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV_BITS   = 16,
    parameter int GUARD      = 2,
    parameter int ACTIVE_LOW = 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  LE,
    input  logic                  lz_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int                 IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_BITS-1:0] GUARD_V = DIV_BITS'(GUARD);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [7:0]         SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0]  AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_BITS-1:0]  r_pre;
    logic [IDX_W-1:0]     r_idx;
    logic [4*DIGITS-1:0]  r_data;
    logic [DIGITS-1:0]    r_point;
    logic [DIGITS-1:0]    r_blank;
    logic                 r_lz_en;

    logic [3:0]           w_nib;
    logic                 w_pt;
    logic                 w_blk;
    logic                 w_upper_zero;
    logic [DIGITS-1:0]    w_sel;
    logic [6:0]           w_font;
    logic                 w_guard;
    logic                 w_suppress;
    logic [7:0]           w_seg_ah;
    logic [DIGITS-1:0]    w_an_ah;

    // Select the current digit's latched fields; w_upper_zero is set when
    // this digit and every more-significant digit hold zero.
    always_comb begin
        w_nib        = 4'h0;
        w_pt         = 1'b0;
        w_blk        = 1'b0;
        w_sel        = '0;
        w_upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib    = r_data[4*i +: 4];
                w_pt     = r_point[i];
                w_blk    = r_blank[i];
                w_sel[i] = 1'b1;
            end
            if ((IDX_W'(i) >= r_idx) && (r_data[4*i +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    hex7seg_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_font)
    );

    always_comb begin
        w_guard    = (r_pre < GUARD_V);
        w_suppress = r_lz_en && (r_idx != '0) && w_upper_zero;
        w_seg_ah   = 8'h00;
        if (!w_guard && !w_blk) begin
            w_seg_ah[SEG_P] = w_pt;
            if (!w_suppress) begin
                w_seg_ah[SEG_G:SEG_A] = w_font;
            end
        end
        w_an_ah = w_guard ? '0 : w_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_point <= '0;
            r_blank <= '0;
            r_lz_en <= 1'b0;
            seg     <= SEG_OFF;
            an      <= AN_OFF;
        end else begin
            r_pre <= r_pre + 1'b1;
            if (r_pre == '1) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (!LE) begin
                r_data  <= data;
                r_point <= point;
                r_blank <= blank;
                r_lz_en <= lz_en;
            end
            seg <= (ACTIVE_LOW != 0) ? ~w_seg_ah : w_seg_ah;
            an  <= (ACTIVE_LOW != 0) ? ~w_an_ah  : w_an_ah;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
module tb_hex_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  point;
    logic [3:0]  blank;
    logic        LE;
    logic        lz_en;
    logic [7:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hex_scan_display #(
        .DIGITS     (4),
        .DIV_BITS   (2),
        .GUARD      (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .point (point),
        .blank (blank),
        .LE    (LE),
        .lz_en (lz_en),
        .seg   (seg),
        .an    (an)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full slot: a guard cycle, then three cycles with the digit lit.
    task automatic check_slot(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        tick();
        chk({tag, "_guard_an"},  {4'h0, an}, 8'h0F);
        chk({tag, "_guard_seg"}, seg,        8'hFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({tag, "_an"},  {4'h0, an}, {4'h0, exp_an});
            chk({tag, "_seg"}, seg,        exp_seg);
        end
    endtask

    initial begin
        rst   = 1'b1;
        data  = 16'h0000;
        point = 4'b0000;
        blank = 4'b0000;
        LE    = 1'b0;
        lz_en = 1'b0;

        // Reset held for three edges
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_seg", seg, 8'hFF);
            chk("rst_an",  {4'h0, an}, 8'h0F);
        end

        // Release; first cycle is guard, then digit 0
        rst  = 1'b0;
        data = 16'h1234;
        tick();
        chk("rel_guard_an", {4'h0, an}, 8'h0F);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rel_d0_an",  {4'h0, an}, 8'h0E);
            chk("rel_d0_seg", seg,        8'h99);
        end

        // Scan 1234
        check_slot("scan_d1", 4'b1101, 8'hB0);
        check_slot("scan_d2", 4'b1011, 8'hA4);
        check_slot("scan_d3", 4'b0111, 8'hF9);
        check_slot("scan_d0", 4'b1110, 8'h99);

        // Latch held over two full scans
        LE   = 1'b1;
        data = 16'hFFFF;
        for (int s = 0; s < 2; s++) begin
            check_slot("hold_d1", 4'b1101, 8'hB0);
            check_slot("hold_d2", 4'b1011, 8'hA4);
            check_slot("hold_d3", 4'b0111, 8'hF9);
            check_slot("hold_d0", 4'b1110, 8'h99);
        end

        // Transparent again: all F
        LE = 1'b0;
        check_slot("open_d1", 4'b1101, 8'h8E);
        check_slot("open_d2", 4'b1011, 8'h8E);
        check_slot("open_d3", 4'b0111, 8'h8E);
        check_slot("open_d0", 4'b1110, 8'h8E);

        // Leading-zero suppression, point on digit 3
        data  = 16'h0050;
        lz_en = 1'b1;
        point = 4'b1000;
        check_slot("lz_d1", 4'b1101, 8'h92);
        check_slot("lz_d2", 4'b1011, 8'hFF);
        check_slot("lz_d3", 4'b0111, 8'h7F);
        check_slot("lz_d0", 4'b1110, 8'hC0);

        // Blank digit 0 overrides its point
        blank = 4'b0001;
        point = 4'b0001;
        check_slot("blk_d1", 4'b1101, 8'h92);
        check_slot("blk_d2", 4'b1011, 8'hFF);
        check_slot("blk_d3", 4'b0111, 8'hFF);
        check_slot("blk_d0", 4'b1110, 8'hFF);

        // Mid-slot reset during digit 2
        check_slot("pre_d1", 4'b1101, 8'h92);
        tick();
        chk("mid_guard_an", {4'h0, an}, 8'h0F);
        tick();
        chk("mid_d2_an", {4'h0, an}, 8'h0B);
        rst   = 1'b1;
        blank = 4'b0000;
        tick();
        chk("mid_rst_an",  {4'h0, an}, 8'h0F);
        chk("mid_rst_seg", seg,        8'hFF);
        rst = 1'b0;
        tick();
        chk("restart_guard_an",  {4'h0, an}, 8'h0F);
        chk("restart_guard_seg", seg,        8'hFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("restart_d0_an",  {4'h0, an}, 8'h0E);
            chk("restart_d0_seg", seg,        8'h40);
        end
        check_slot("restart_d1", 4'b1101, 8'h92);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning number of multiplexed hex digits (legal 1..8).
REQ-002 The block SHALL have parameter DIV_BITS, default 16, meaning prescaler width; each digit is selected for 2^DIV_BITS clk cycles.
REQ-003 The block SHALL have parameter GUARD, default 2, meaning all-anodes-off cycles at the start of each digit slot (legal 0..2^DIV_BITS-1).
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1, meaning that when 1, seg and an are driven active-low.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port data, input, 4*DIGITS bits; nibble i (data[4i+3:4i]) is digit i, digit 0 rightmost.
REQ-008 The block SHALL have port point, input, DIGITS bits; bit i lights the decimal point of digit i.
REQ-009 The block SHALL have port blank, input, DIGITS bits; bit i forces digit i fully dark.
REQ-010 The block SHALL have port LE, input, 1 bit, latch enable: 0 = transparent (capture every cycle), 1 = hold the last captured values.
REQ-011 The block SHALL have port lz_en, input, 1 bit, enabling leading-zero suppression.
REQ-012 The block SHALL have port seg, output, 8 bits, ordered {p,g,f,e,d,c,b,a}.
REQ-013 The block SHALL have port an, output, DIGITS bits; bit i enables digit i.

Function
REQ-014 Latch registers for data, point and blank SHALL load on every clk edge with LE=0 and hold with LE=1; the captured lz_en SHALL follow the same rule.
REQ-015 The prescaler SHALL increment every cycle and wrap from 2^DIV_BITS-1 to 0; on that wrap, digit index idx SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-016 seg and an SHALL be registered, computed from the idx, prescaler and latched values of the previous cycle (1-cycle output latency).
REQ-017 While prescaler < GUARD, all an bits SHALL be inactive and seg all-off.
REQ-018 Otherwise only an[idx] SHALL be active.
REQ-019 Segment font (active-high {g..a}) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; p = point[idx].
REQ-020 Digit idx SHALL be leading-zero-suppressed when lz_en=1, idx>0, and nibbles idx..DIGITS-1 are all 0; a suppressed digit SHALL show g..a all off with p still equal to point[idx].
REQ-021 A blanked digit (blank[idx]=1) SHALL show all segments including p off; blank SHALL take precedence over point and suppression.
REQ-022 When ACTIVE_LOW=1, seg and an SHALL be bitwise inverted versions of the active-high values.
REQ-023 An input change with LE=0 SHALL appear on seg no later than 2 cycles after the affected digit's guard period ends.

Reset
REQ-024 With rst=1 at a clk edge, the prescaler, idx and all latch registers SHALL be cleared to 0.
REQ-025 With rst=1 at a clk edge, seg and an SHALL be set to all-inactive (all ones when ACTIVE_LOW=1).
REQ-026 rst SHALL dominate LE and any scan event in the same cycle.
REQ-027 Reset asserted mid-slot SHALL abort the slot; scanning SHALL restart at idx 0 with a full guard period on the first cycle after rst deasserts.

Structure
REQ-028 Package seg7_pkg SHALL hold the 16-entry font constant and the segment-order constants.
REQ-029 A combinational sub-module hex7seg_dec (nibble in, 7 bits out) SHALL be instantiated once, fed by the latched nibble selected by idx.
REQ-030 Prescaler, idx, latches and output registers SHALL reside in hex_scan_display.

Verification (DIGITS=4, DIV_BITS=2, GUARD=1, ACTIVE_LOW=1)
REQ-031 Reset: hold rst=1 for 3 cycles -> seg=8'hFF and an=4'hF from the first edge; after release, an=4'hF for 1 cycle, then 4'b1110.
REQ-032 Scan: data=16'h1234, LE=0 -> an sequence 1110,1101,1011,0111 with each slot 4 cycles, the first off; seg=8'h99, 8'hB0, 8'hA4, 8'hF9 respectively.
REQ-033 Latch: LE=1, then data=16'hFFFF -> display unchanged over 2 full scans; LE=0 -> seg=8'h8E on each digit within 2 cycles of its guard end.
REQ-034 Suppression: data=16'h0050, lz_en=1, point=4'b1000 -> digit3 seg=8'h7F, digit2 seg=8'hFF, digit1 seg=8'h92, digit0 seg=8'hC0.
REQ-035 Blank: blank=4'b0001, point=4'b0001 -> digit0 seg=8'hFF while an[0]=0.
REQ-036 Mid-slot reset: assert rst during idx=2 -> next cycle an=4'hF; after release, scanning restarts at digit 0.
